// File: rtl/alu_apb_arbiter_if.sv
// Signal bundle for the two requester command ports and the shared APB bus of alu_apb_arbiter.
// The arbiter connects through the master modport; the environment uses the slave modport.
interface alu_apb_arbiter_if;
  logic        m0_req;
  logic        m0_write;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_done;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_write;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_done;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    input  prdata, pready,
    output m0_done, m0_rdata, m0_err,
    output m1_done, m1_rdata, m1_err,
    output psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output m0_req, m0_write, m0_addr, m0_wdata,
    output m1_req, m1_write, m1_addr, m1_wdata,
    output prdata, pready,
    input  m0_done, m0_rdata, m0_err,
    input  m1_done, m1_rdata, m1_err,
    input  psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/alu_apb_arbiter.sv
// Round-robin arbiter serialising two requesters' single read/write commands onto one APB bus,
// with address-window rejection and a pready timeout. Every output is registered.
module alu_apb_arbiter #(
  parameter logic [31:0] ADDR_LO     = 32'h10,
  parameter logic [31:0] ADDR_HI     = 32'h1C,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input logic               clk,
  input logic               reset_n,
  alu_apb_arbiter_if.master bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;
  logic            wr_q, wr_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            sel;
  logic            sel_write;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic            legal;
  logic            resp_err;
  logic [31:0]     resp_rdata;
  logic            bus_d;

  logic            psel_q, penable_q, pwrite_q;
  logic [31:0]     paddr_q, pwdata_q;
  logic            done0_q, done1_q, err0_q, err1_q;
  logic [31:0]     rdata0_q, rdata1_q;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    sel       = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
    sel_write = sel ? bus.m1_write : bus.m0_write;
    sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
    legal     = (sel_addr >= ADDR_LO) && (sel_addr <= ADDR_HI) && (sel_addr[1:0] == 2'b00);
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    resp_err   = 1'b0;
    resp_rdata = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.m0_req || bus.m1_req) begin
          gnt_d   = sel;
          last_d  = sel;
          wr_d    = sel_write;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (legal) begin
            state_d = StSetup;
          end else begin
            state_d  = StResp;
            resp_err = 1'b1;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = '0;
      end
      StAccess: begin
        if (bus.pready) begin
          state_d    = StResp;
          resp_rdata = wr_q ? 32'h0 : bus.prdata;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          state_d  = StResp;
          resp_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus_d = (state_d == StSetup) || (state_d == StAccess);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      // APB fields are forced to zero whenever psel is low.
      psel_q    <= bus_d;
      penable_q <= (state_d == StAccess);
      pwrite_q  <= bus_d ? wr_d : 1'b0;
      paddr_q   <= bus_d ? addr_d : 32'h0;
      pwdata_q  <= bus_d ? wdata_d : 32'h0;
      done0_q   <= (state_d == StResp) && !gnt_d;
      done1_q   <= (state_d == StResp) && gnt_d;
      err0_q    <= (state_d == StResp) && !gnt_d && resp_err;
      err1_q    <= (state_d == StResp) && gnt_d && resp_err;
      rdata0_q  <= ((state_d == StResp) && !gnt_d) ? resp_rdata : 32'h0;
      rdata1_q  <= ((state_d == StResp) && gnt_d) ? resp_rdata : 32'h0;
    end
  end

  assign bus.psel     = psel_q;
  assign bus.penable  = penable_q;
  assign bus.pwrite   = pwrite_q;
  assign bus.paddr    = paddr_q;
  assign bus.pwdata   = pwdata_q;
  assign bus.m0_done  = done0_q;
  assign bus.m1_done  = done1_q;
  assign bus.m0_err   = err0_q;
  assign bus.m1_err   = err1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;

endmodule

// File: tb/tb_alu_apb_arbiter.sv
// Bench for alu_apb_arbiter: directed commands against a small register slave, with a
// transaction-level expectation queue checked every cycle plus hand-computed latencies and data.
module tb_alu_apb_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_apb_arbiter_if bus ();

  alu_apb_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          psel_cnt = 0;
  int          model_last;
  logic        slave_ready;
  logic [31:0] slv_mem [4];
  logic [31:0] model_mem [4];
  exp_t        exp_q [$];
  logic        prev_psel = 1'b0;
  logic        prev_pwrite = 1'b0;
  logic [31:0] prev_paddr = 32'h0;
  logic [31:0] prev_pwdata = 32'h0;

  // The ALU slave keeps only four bits of the register at 0x14.
  function automatic logic [31:0] slave_mask(input logic [1:0] idx);
    return (idx == 2'd1) ? 32'h0000000F : 32'hFFFFFFFF;
  endfunction

  assign bus.pready = slave_ready;
  assign bus.prdata = bus.psel ? slv_mem[bus.paddr[3:2]] : 32'h0;

  always @(posedge clk) begin
    if (bus.psel && bus.penable && bus.pready && bus.pwrite)
      slv_mem[bus.paddr[3:2]] <= bus.pwdata & slave_mask(bus.paddr[3:2]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // What a command must return, from the address window, timeout and slave register rules.
  task automatic model_push(input int id, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
    exp_t e;
    e.id    = id;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    if (a < 32'h10 || a > 32'h1C || a[1:0] != 2'b00) e.err = 1'b1;
    else if (!slave_ready) e.err = 1'b1;
    else if (w) model_mem[a[3:2]] = d & slave_mask(a[3:2]);
    else e.rdata = model_mem[a[3:2]];
    exp_q.push_back(e);
    model_last = id;
  endtask

  task automatic compare_req(input int id, input logic done, input logic [31:0] rdata,
                             input logic err);
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done m%0d actual=1 expected=0", id);
      end else begin
        e = exp_q.pop_front();
        check("done_requester", 32'(id), 32'(e.id));
        check("done_rdata", rdata, e.rdata);
        check("done_err", 32'(err), 32'(e.err));
        check("resp_bus_idle", 32'({bus.psel, bus.penable}), 32'h0);
      end
    end else begin
      check("idle_outputs_zero", rdata | 32'(err), 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (!bus.psel) begin
      check("apb_idle_zero",
            32'(bus.penable | bus.pwrite | (|bus.paddr) | (|bus.pwdata)), 32'h0);
    end else begin
      psel_cnt++;
    end
    if (bus.penable) begin
      check("penable_after_psel", 32'(prev_psel), 32'h1);
      check("apb_addr_stable", bus.paddr, prev_paddr);
      check("apb_wdata_stable", bus.pwdata, prev_pwdata);
      check("apb_write_stable", 32'(bus.pwrite), 32'(prev_pwrite));
    end
    check("single_done", 32'(bus.m0_done & bus.m1_done), 32'h0);
    compare_req(0, bus.m0_done, bus.m0_rdata, bus.m0_err);
    compare_req(1, bus.m1_done, bus.m1_rdata, bus.m1_err);
    prev_psel   <= bus.psel;
    prev_pwrite <= bus.pwrite;
    prev_paddr  <= bus.paddr;
    prev_pwdata <= bus.pwdata;
  end

  // Latencies are counted in cycles from the cycle in which req is raised.
  task automatic transact(input logic en0, input logic w0, input logic [31:0] a0,
                          input logic [31:0] d0, input logic en1, input logic w1,
                          input logic [31:0] a1, input logic [31:0] d1,
                          output int lat0, output int lat1, output logic [31:0] r0,
                          output logic [31:0] r1, output logic e0, output logic e1);
    int   first;
    int   n;
    logic pend0;
    logic pend1;
    lat0 = -1;
    lat1 = -1;
    r0   = 32'h0;
    r1   = 32'h0;
    e0   = 1'b0;
    e1   = 1'b0;
    if (en0 && en1) first = (model_last == 1) ? 0 : 1;
    else first = en1 ? 1 : 0;
    if (first == 0) begin
      if (en0) model_push(0, w0, a0, d0);
      if (en1) model_push(1, w1, a1, d1);
    end else begin
      if (en1) model_push(1, w1, a1, d1);
      if (en0) model_push(0, w0, a0, d0);
    end
    @(posedge clk);
    #1;
    bus.m0_req   = en0;
    bus.m0_write = w0;
    bus.m0_addr  = a0;
    bus.m0_wdata = d0;
    bus.m1_req   = en1;
    bus.m1_write = w1;
    bus.m1_addr  = a1;
    bus.m1_wdata = d1;
    pend0 = en0;
    pend1 = en1;
    n = 0;
    while ((pend0 || pend1) && n < 64) begin
      @(negedge clk);
      if (pend0 && bus.m0_done) begin
        lat0 = n;
        r0   = bus.m0_rdata;
        e0   = bus.m0_err;
        pend0 = 1'b0;
        bus.m0_req = 1'b0;
      end
      if (pend1 && bus.m1_done) begin
        lat1 = n;
        r1   = bus.m1_rdata;
        e1   = bus.m1_err;
        pend1 = 1'b0;
        bus.m1_req = 1'b0;
      end
      n++;
    end
    if (pend0 || pend1) begin
      checks++;
      errors++;
      $display("FAIL done_wait pending m0=%0d m1=%0d expected none", pend0, pend1);
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
    end
  endtask

  initial begin
    int          lat0;
    int          lat1;
    int          p0;
    logic [31:0] r0;
    logic [31:0] r1;
    logic        e0;
    logic        e1;

    reset_n      = 1'b1;
    bus.m0_req   = 1'b0;
    bus.m0_write = 1'b0;
    bus.m0_addr  = 32'h0;
    bus.m0_wdata = 32'h0;
    bus.m1_req   = 1'b0;
    bus.m1_write = 1'b0;
    bus.m1_addr  = 32'h0;
    bus.m1_wdata = 32'h0;
    slave_ready  = 1'b1;
    model_last   = 1;
    for (int i = 0; i < 4; i++) model_mem[i] = 32'h0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 32'({bus.psel, bus.penable, bus.pwrite, bus.m0_done, bus.m1_done,
                             bus.m0_err, bus.m1_err}), 32'h0);
    check("reset_data", bus.paddr | bus.pwdata | bus.m0_rdata | bus.m1_rdata, 32'h0);
    #2 reset_n = 1'b1;

    // Tie after reset: m0 first; m1 then reads what m0 wrote.
    transact(1'b1, 1'b1, 32'h18, 32'h12345678, 1'b1, 1'b0, 32'h18, 32'h0,
             lat0, lat1, r0, r1, e0, e1);
    check("tie1_m0_lat", 32'(lat0), 32'd3);
    check("tie1_m1_lat", 32'(lat1), 32'd7);
    check("tie1_m1_rdata", r1, 32'h12345678);

    transact(1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             lat0, lat1, r0, r1, e0, e1);
    check("m0_single_lat", 32'(lat0), 32'd3);
    check("m0_single_rdata", r0, 32'h12345678);

    // Last grant was m0, so m1 now wins the tie.
    transact(1'b1, 1'b0, 32'h1C, 32'h0, 1'b1, 1'b1, 32'h1C, 32'hA5A5A5A5,
             lat0, lat1, r0, r1, e0, e1);
    check("tie2_m1_lat", 32'(lat1), 32'd3);
    check("tie2_m0_lat", 32'(lat0), 32'd7);
    check("tie2_m0_rdata", r0, 32'hA5A5A5A5);

    transact(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0,
             lat0, lat1, r0, r1, e0, e1);
    check("wr10_lat", 32'(lat0), 32'd3);
    check("wr10_rdata_err", r0 | 32'(e0), 32'h0);
    transact(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             lat0, lat1, r0, r1, e0, e1);
    check("rd10_lat", 32'(lat0), 32'd3);
    check("rd10_rdata", r0, 32'hDEADBEEF);
    check("rd10_err", 32'(e0), 32'h0);

    p0 = psel_cnt;
    transact(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
             lat0, lat1, r0, r1, e0, e1);
    check("oow_lat", 32'(lat1), 32'd1);
    check("oow_err", 32'(e1), 32'h1);
    check("oow_rdata", r1, 32'h0);
    transact(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h12, 32'h0,
             lat0, lat1, r0, r1, e0, e1);
    check("misalign_lat", 32'(lat1), 32'd1);
    check("misalign_err", 32'(e1), 32'h1);
    check("illegal_no_psel", 32'(psel_cnt - p0), 32'h0);

    transact(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h14, 32'hFFFFFFFF,
             lat0, lat1, r0, r1, e0, e1);
    transact(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0,
             lat0, lat1, r0, r1, e0, e1);
    check("mask14_rdata", r1, 32'h0000000F);

    slave_ready = 1'b0;
    transact(1'b1, 1'b1, 32'h18, 32'h0BADF00D, 1'b0, 1'b0, 32'h0, 32'h0,
             lat0, lat1, r0, r1, e0, e1);
    check("timeout_lat", 32'(lat0), 32'd18);
    check("timeout_err", 32'(e0), 32'h1);
    check("timeout_rdata", r0, 32'h0);

    // Reset while the slave stalls in ACCESS: the command is dropped without a done pulse.
    @(posedge clk);
    #1;
    bus.m0_req   = 1'b1;
    bus.m0_write = 1'b0;
    bus.m0_addr  = 32'h18;
    repeat (4) @(negedge clk);
    check("stall_in_access", 32'({bus.psel, bus.penable}), 32'h3);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_clear", 32'({bus.psel, bus.penable, bus.m0_done}), 32'h0);
    bus.m0_req  = 1'b0;
    model_last  = 1;
    @(posedge clk);
    #2 reset_n = 1'b1;
    slave_ready = 1'b1;

    transact(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0,
             lat0, lat1, r0, r1, e0, e1);
    check("post_reset_m0_lat", 32'(lat0), 32'd3);
    check("post_reset_m1_lat", 32'(lat1), 32'd7);
    check("post_reset_m0_rdata", r0, 32'hDEADBEEF);
    check("post_reset_m1_rdata", r1, 32'h0000000F);

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired expected=finished");
    $fatal(1);
  end
endmodule
